// File: rtl/line_window_ctrl.sv
// line_window_ctrl
// Sequences the four single-port row RAMs of a 5-row line buffer. Each accepted
// raster pixel is written over the oldest stored row, and one cycle later a
// 5-pixel vertical column (rows r-4..r) is presented for a 5x5 window filter.
//
// Ports
//   clka, rsta            clock, asynchronous active-high reset
//   s_valid/s_sof/s_data  input pixel stream (no backpressure)
//   ram_addr/ram_din      shared address / write data to the four RAMs
//   ram_en/ram_we         per-RAM enable / one-hot write enable
//   ram_dout1..4          read data from RAM 0..3 (read-first, 1-cycle latency)
//   m_valid/m_col         output column, [DW-1:0] = newest row r
//   m_col_idx/m_row_idx   position of the column
//   m_win_ok              all five rows belong to the current frame
//   frame_done            pulse with the last column of the frame
//   sof_err               pulse when s_sof arrives away from (row 0, col 0)
module line_window_ctrl #(
    parameter int P_ROW_WIDTH     = 256,
    parameter int P_COL_HEIGHT    = 192,
    parameter int P_DATA_WIDTH    = 8,
    parameter int P_ADDR_WIDTH    = 11,
    parameter int P_ROW_CNT_WIDTH = 10
) (
    input  logic                        clka,
    input  logic                        rsta,
    input  logic                        s_valid,
    input  logic                        s_sof,
    input  logic [P_DATA_WIDTH-1:0]     s_data,
    output logic [P_ADDR_WIDTH-1:0]     ram_addr,
    output logic [P_DATA_WIDTH-1:0]     ram_din,
    output logic [3:0]                  ram_en,
    output logic [3:0]                  ram_we,
    input  logic [P_DATA_WIDTH-1:0]     ram_dout1,
    input  logic [P_DATA_WIDTH-1:0]     ram_dout2,
    input  logic [P_DATA_WIDTH-1:0]     ram_dout3,
    input  logic [P_DATA_WIDTH-1:0]     ram_dout4,
    output logic                        m_valid,
    output logic [5*P_DATA_WIDTH-1:0]   m_col,
    output logic [P_ADDR_WIDTH-1:0]     m_col_idx,
    output logic [P_ROW_CNT_WIDTH-1:0]  m_row_idx,
    output logic                        m_win_ok,
    output logic                        frame_done,
    output logic                        sof_err
);

    localparam int DW = P_DATA_WIDTH;
    localparam int AW = P_ADDR_WIDTH;
    localparam int RW = P_ROW_CNT_WIDTH;
    localparam logic [AW-1:0] COL_LAST = AW'(P_ROW_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(P_COL_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(4);

    logic [AW-1:0] col, col_eff, col_nxt;
    logic [RW-1:0] row, row_eff, row_nxt;
    logic [1:0]    wr_sel, sel_eff, sel_nxt;
    logic          last_pix, at_origin;

    logic [AW-1:0] addr_hold;
    logic [DW-1:0] din_hold;

    logic [DW-1:0] data_d;
    logic [1:0]    wr_sel_d;
    logic [1:0]    sel_m1, sel_m2, sel_m3;
    logic [DW-1:0] dout [4];

    // s_sof forces the pixel to (0,0) with RAM 0 as the row to overwrite.
    always_comb begin
        col_eff   = s_sof ? '0 : col;
        row_eff   = s_sof ? '0 : row;
        sel_eff   = s_sof ? '0 : wr_sel;
        at_origin = (col == '0) && (row == '0);
        last_pix  = (col_eff == COL_LAST) && (row_eff == ROW_LAST);
    end

    always_comb begin
        col_nxt = col_eff + AW'(1);
        row_nxt = row_eff;
        sel_nxt = sel_eff;
        if (col_eff == COL_LAST) begin
            col_nxt = '0;
            if (row_eff == ROW_LAST) begin
                row_nxt = '0;
                sel_nxt = '0;
            end else begin
                row_nxt = row_eff + RW'(1);
                sel_nxt = sel_eff + 2'd1;
            end
        end
    end

    // RAM port: live values on accept, otherwise the last address/data hold.
    always_comb begin
        ram_en   = {4{s_valid}};
        ram_we   = s_valid ? (4'b0001 << sel_eff) : 4'b0000;
        ram_addr = s_valid ? col_eff : addr_hold;
        ram_din  = s_valid ? s_data  : din_hold;
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            col       <= '0;
            row       <= '0;
            wr_sel    <= '0;
            addr_hold <= '0;
            din_hold  <= '0;
        end else if (s_valid) begin
            col       <= col_nxt;
            row       <= row_nxt;
            wr_sel    <= sel_nxt;
            addr_hold <= col_eff;
            din_hold  <= s_data;
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            m_valid    <= 1'b0;
            m_win_ok   <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
            m_col_idx  <= '0;
            m_row_idx  <= '0;
            data_d     <= '0;
            wr_sel_d   <= '0;
        end else begin
            m_valid    <= s_valid;
            m_win_ok   <= s_valid && (row_eff >= ROW_WIN);
            frame_done <= s_valid && last_pix;
            sof_err    <= s_valid && s_sof && !at_origin;
            if (s_valid) begin
                m_col_idx <= col_eff;
                m_row_idx <= row_eff;
                data_d    <= s_data;
                wr_sel_d  <= sel_eff;
            end
        end
    end

    // Slice k (row r-k) comes from RAM (wr_sel_d - k) mod 4; the 2-bit
    // subtraction wraps naturally, and k=4 lands back on wr_sel_d, whose
    // read-first data is the row that was just overwritten.
    assign dout[0] = ram_dout1;
    assign dout[1] = ram_dout2;
    assign dout[2] = ram_dout3;
    assign dout[3] = ram_dout4;

    always_comb begin
        sel_m1 = wr_sel_d - 2'd1;
        sel_m2 = wr_sel_d - 2'd2;
        sel_m3 = wr_sel_d - 2'd3;
        m_col  = {dout[wr_sel_d], dout[sel_m3], dout[sel_m2], dout[sel_m1], data_d};
    end

endmodule

// File: tb/tb_line_window_ctrl.sv
module tb_line_window_ctrl;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;
    localparam int AW = 11;
    localparam int RW = 10;

    logic              clka = 1'b0;
    logic              rsta;
    logic              s_valid, s_sof;
    logic [DW-1:0]     s_data;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_din;
    logic [3:0]        ram_en, ram_we;
    logic [DW-1:0]     rd [4];
    logic              m_valid, m_win_ok, frame_done, sof_err;
    logic [5*DW-1:0]   m_col;
    logic [AW-1:0]     m_col_idx;
    logic [RW-1:0]     m_row_idx;

    always #5 clka = ~clka;

    line_window_ctrl #(
        .P_ROW_WIDTH(W), .P_COL_HEIGHT(H), .P_DATA_WIDTH(DW),
        .P_ADDR_WIDTH(AW), .P_ROW_CNT_WIDTH(RW)
    ) dut (
        .clka(clka), .rsta(rsta),
        .s_valid(s_valid), .s_sof(s_sof), .s_data(s_data),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_en(ram_en), .ram_we(ram_we),
        .ram_dout1(rd[0]), .ram_dout2(rd[1]), .ram_dout3(rd[2]), .ram_dout4(rd[3]),
        .m_valid(m_valid), .m_col(m_col), .m_col_idx(m_col_idx), .m_row_idx(m_row_idx),
        .m_win_ok(m_win_ok), .frame_done(frame_done), .sof_err(sof_err)
    );

    // Four read-first RAMs with 1-cycle read latency.
    logic [DW-1:0] mem [4][256];
    always @(posedge clka) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_en[i]) begin
                rd[i] <= mem[i][ram_addr[7:0]];
                if (ram_we[i]) mem[i][ram_addr[7:0]] <= ram_din;
            end
        end
    end

    typedef struct {
        int          col;
        int          row;
        bit          win;
        bit          fd;
        bit          se;
        bit          chk;
        logic [39:0] mcol;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            mcol_m = 0;
    int            mrow_m = 0;
    bit            prev_v = 1'b0;
    logic [7:0]    img [H][W];
    bit            imv [H][W];
    logic [3:0]    we_tab [H];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_valid();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                imv[r][c] = 1'b0;
    endtask

    task automatic check_out();
        exp_t e;
        chk("m_valid", 64'(m_valid), 64'(prev_v));
        if (prev_v) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("m_col_idx", 64'(m_col_idx), 64'(e.col));
                chk("m_row_idx", 64'(m_row_idx), 64'(e.row));
                chk("m_win_ok", 64'(m_win_ok), 64'(e.win));
                chk("frame_done", 64'(frame_done), 64'(e.fd));
                chk("sof_err", 64'(sof_err), 64'(e.se));
                if (e.chk) chk("m_col", 64'(m_col), 64'(e.mcol));
                if (e.chk && e.row == 4 && e.col == 3)
                    chk("m_col_r4c3", 64'(m_col), 64'h03_13_23_33_43);
            end
        end else begin
            chk("idle_win_ok", 64'(m_win_ok), 64'd0);
            chk("idle_frame_done", 64'(frame_done), 64'd0);
            chk("idle_sof_err", 64'(sof_err), 64'd0);
        end
    endtask

    // One clock of stimulus; the pixel value is row*16+col of its expected position.
    task automatic step(input bit v, input bit sof);
        exp_t e;
        int ec, er;
        @(negedge clka);
        check_out();
        ec = sof ? 0 : mcol_m;
        er = sof ? 0 : mrow_m;
        s_valid = v;
        s_sof   = sof;
        s_data  = v ? 8'(er * 16 + ec) : 8'($urandom);
        #1;
        if (v) begin
            if (sof) clear_valid();
            if (ec == 0) chk("ram_we_row", 64'(ram_we), 64'(we_tab[er]));
            chk("ram_en", 64'(ram_en), 64'hF);
            chk("ram_addr", 64'(ram_addr), 64'(ec));
            chk("ram_din", 64'(ram_din), 64'(s_data));
            img[er][ec] = s_data;
            imv[er][ec] = 1'b1;
            e.col  = ec;
            e.row  = er;
            e.win  = (er >= 4);
            e.fd   = (er == H - 1) && (ec == W - 1);
            e.se   = sof && (mcol_m != 0 || mrow_m != 0);
            e.chk  = 1'b0;
            e.mcol = '0;
            if (er >= 4) begin
                e.chk  = imv[er-4][ec] && imv[er-3][ec] && imv[er-2][ec] && imv[er-1][ec];
                e.mcol = {img[er-4][ec], img[er-3][ec], img[er-2][ec], img[er-1][ec], img[er][ec]};
            end
            sb.push_back(e);
            if (ec == W - 1) begin
                mcol_m = 0;
                mrow_m = (er == H - 1) ? 0 : er + 1;
            end else begin
                mcol_m = ec + 1;
                mrow_m = er;
            end
        end else begin
            chk("idle_ram_en", 64'(ram_en), 64'd0);
            chk("idle_ram_we", 64'(ram_we), 64'd0);
        end
        prev_v = v;
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clka);
        check_out();
        rsta = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            s_valid = 1'($urandom);
            s_sof   = 1'($urandom);
            s_data  = 8'($urandom);
            #1;
            chk("rst_m_valid", 64'(m_valid), 64'd0);
            chk("rst_outs", 64'({m_win_ok, frame_done, sof_err}), 64'd0);
            chk("rst_idx", 64'({m_col_idx, m_row_idx}), 64'd0);
            if (!s_valid) chk("rst_ram_we", 64'(ram_we), 64'd0);
            @(negedge clka);
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        rsta    = 1'b0;
        sb.delete();
        prev_v = 1'b0;
        mcol_m = 0;
        mrow_m = 0;
        clear_valid();
    endtask

    initial begin
        int n;
        we_tab[0] = 4'b0001; we_tab[1] = 4'b0010; we_tab[2] = 4'b0100;
        we_tab[3] = 4'b1000; we_tab[4] = 4'b0001; we_tab[5] = 4'b0010;
        rsta = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
        clear_valid();

        apply_reset(6);

        for (int i = 0; i < W * H; i++) step(1'b1, i == 0);

        n = 0;
        while (n < W * H) begin
            if ($urandom_range(9) < 4) step(1'b0, 1'b0);
            else begin
                step(1'b1, n == 0);
                n++;
            end
        end

        step(1'b1, 1'b0);
        while (!(mrow_m == 2 && mcol_m == 5)) step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        while (!(mrow_m == 3 && mcol_m == 2)) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        apply_reset(1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
